// File: rtl/power_rail_sequencer_pkg.sv
// Shared definitions for the rail sequencer: FSM state encodings and the debug state width.
// The LED/debug decoding in the top level uses the same values.
package power_rail_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/power_rail_sequencer_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous level signals.
// Asynchronous active-low reset clears both stages to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             sysclk,
  input  logic             reset_INV,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/power_rail_sequencer.sv
// N-rail power sequencer: ascending enable gated on PG + settle, descending timed teardown,
// PG timeout / PG loss latch a fault that drops every rail at once.
module power_rail_sequencer
  import power_rail_sequencer_pkg::*;
#(
  parameter  int NUM_RAILS     = 4,
  parameter  int TIMER_WIDTH   = 16,
  parameter  int SETTLE_CYCLES = 1024,
  parameter  int PG_TIMEOUT    = 16384,
  parameter  int OFF_DELAY     = 256,
  localparam int RAIL_W        = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
  input  logic                 sysclk,
  input  logic                 reset_INV,
  input  logic                 enable,
  input  logic [NUM_RAILS-1:0] pg_in,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 power_good,
  output logic                 fault,
  output logic [RAIL_W-1:0]    fault_rail,
  output logic [STATE_W-1:0]   state
);

  localparam longint TIMER_SPAN = longint'(1) << TIMER_WIDTH;

  if (NUM_RAILS < 1 || NUM_RAILS > 8 ||
      SETTLE_CYCLES < 1 || longint'(SETTLE_CYCLES) > TIMER_SPAN ||
      PG_TIMEOUT < 1 || longint'(PG_TIMEOUT) > TIMER_SPAN ||
      OFF_DELAY < 1 || longint'(OFF_DELAY) > TIMER_SPAN) begin : g_bad_params
    $error("power_rail_sequencer: illegal parameter combination");
  end

  localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] PG_LAST     = TIMER_WIDTH'(PG_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] OFF_LAST    = TIMER_WIDTH'(OFF_DELAY - 1);
  localparam logic [RAIL_W-1:0]      LAST_IDX    = RAIL_W'(NUM_RAILS - 1);

  seq_state_t                 state_reg,      state_next;
  logic [TIMER_WIDTH-1:0]     cnt_reg,        cnt_next;
  logic [RAIL_W-1:0]          idx_reg,        idx_next;
  logic [NUM_RAILS-1:0]       rail_en_reg,    rail_en_next;
  logic                       fault_reg,      fault_next;
  logic [RAIL_W-1:0]          fault_rail_reg, fault_rail_next;

  logic [NUM_RAILS-1:0]       pg_s;
  logic [NUM_RAILS-1:0]       lost_vec;
  logic [NUM_RAILS-1:0]       timeout_vec;
  logic [NUM_RAILS-1:0]       fail_vec;
  logic [RAIL_W-1:0]          fail_idx;
  logic [RAIL_W-1:0]          idx_inc;
  logic [TIMER_WIDTH-1:0]     cnt_inc;
  logic                       pg_watch;
  logic                       fail_any;

  sync_2ff #(.WIDTH(NUM_RAILS)) u_pg_sync (
    .sysclk    (sysclk),
    .reset_INV (reset_INV),
    .d         (pg_in),
    .q         (pg_s)
  );

  assign pg_watch = (state_reg == ST_RAMP) || (state_reg == ST_SETTLE) || (state_reg == ST_ON);

  // A rail is watched for PG loss only once it has completed its own RAMP phase.
  for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_pg_loss
    logic passed;
    assign passed = rail_en_reg[gi] &&
                    ((RAIL_W'(gi) < idx_reg) ||
                     ((RAIL_W'(gi) == idx_reg) && (state_reg != ST_RAMP)));
    assign lost_vec[gi] = pg_watch && passed && !pg_s[gi];
  end

  assign timeout_vec = ((state_reg == ST_RAMP) && (cnt_reg == PG_LAST) && !pg_s[idx_reg])
                       ? (NUM_RAILS'(1) << idx_reg) : '0;
  assign fail_vec    = lost_vec | timeout_vec;
  assign fail_any    = |fail_vec;

  always_comb begin
    fail_idx = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (fail_vec[j]) fail_idx = RAIL_W'(j);
    end
  end

  assign idx_inc = idx_reg + RAIL_W'(1);
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + TIMER_WIDTH'(1);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    rail_en_next    = rail_en_reg;
    fault_next      = fault_reg;
    fault_rail_next = fault_rail_reg;

    // Fault is checked before enable so a simultaneous fault always wins.
    if (fail_any) begin
      state_next      = ST_FAULT;
      rail_en_next    = '0;
      fault_next      = 1'b1;
      fault_rail_next = fail_idx;
      cnt_next        = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_next   = ST_RAMP;
            idx_next     = '0;
            rail_en_next = NUM_RAILS'(1);
            cnt_next     = '0;
          end
        end
        ST_RAMP: begin
          if (!enable) begin
            state_next            = ST_DOWN;
            rail_en_next[idx_reg] = 1'b0;
            cnt_next              = '0;
          end else if (pg_s[idx_reg]) begin
            state_next = ST_SETTLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_SETTLE: begin
          if (!enable) begin
            state_next            = ST_DOWN;
            rail_en_next[idx_reg] = 1'b0;
            cnt_next              = '0;
          end else if (cnt_reg == SETTLE_LAST) begin
            cnt_next = '0;
            if (idx_reg == LAST_IDX) begin
              state_next = ST_ON;
            end else begin
              state_next            = ST_RAMP;
              idx_next              = idx_inc;
              rail_en_next[idx_inc] = 1'b1;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_ON: begin
          if (!enable) begin
            state_next             = ST_DOWN;
            idx_next               = LAST_IDX;
            rail_en_next[LAST_IDX] = 1'b0;
            cnt_next               = '0;
          end
        end
        ST_DOWN: begin
          // idx names the rail cleared most recently; at idx 0 the final delay ends teardown.
          if (cnt_reg == OFF_LAST) begin
            cnt_next = '0;
            if (idx_reg == '0) begin
              state_next = ST_IDLE;
            end else begin
              idx_next                          = idx_reg - RAIL_W'(1);
              rail_en_next[idx_reg - RAIL_W'(1)] = 1'b0;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            state_next      = ST_IDLE;
            fault_next      = 1'b0;
            fault_rail_next = '0;
            idx_next        = '0;
            cnt_next        = '0;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          rail_en_next = '0;
          cnt_next     = '0;
          idx_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      rail_en_reg    <= '0;
      fault_reg      <= 1'b0;
      fault_rail_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      rail_en_reg    <= rail_en_next;
      fault_reg      <= fault_next;
      fault_rail_reg <= fault_rail_next;
    end
  end

  assign rail_en    = rail_en_reg;
  assign power_good = (state_reg == ST_ON);
  assign fault      = fault_reg;
  assign fault_rail = fault_rail_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Randomised scenario bench: expected output events are timestamped from the sequencing rules
// and queued; a negedge monitor pops one event per observed output change and compares it.
module tb_power_rail_sequencer;

  localparam int N        = 4;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 100;
  localparam int OFFD     = 8;
  localparam int PG_DELAY = 3;
  localparam int SYNC_LAT = 2;
  localparam int STEP     = PG_DELAY + SYNC_LAT + SETTLE;

  localparam logic [2:0] S_IDLE = 3'd0, S_RAMP = 3'd1, S_ON = 3'd3,
                         S_DOWN = 3'd4, S_FAULT = 3'd5;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       enable;
  logic [3:0] pg_in;
  logic [3:0] rail_en;
  logic       power_good;
  logic       fault;
  logic [1:0] fault_rail;
  logic [2:0] state;

  power_rail_sequencer #(
    .NUM_RAILS(N), .TIMER_WIDTH(16), .SETTLE_CYCLES(SETTLE),
    .PG_TIMEOUT(TIMEOUT), .OFF_DELAY(OFFD)
  ) dut (
    .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable), .pg_in(pg_in),
    .rail_en(rail_en), .power_good(power_good), .fault(fault),
    .fault_rail(fault_rail), .state(state)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Regulator model: rail_en after edge k is seen by the synchroniser at edge k+3.
  logic [3:0] h1 = '0, h2 = '0, pg_raw = '0;
  logic [3:0] drop_mask = '0;
  always @(negedge sysclk) begin
    pg_raw = h2;
    h2     = h1;
    h1     = rail_en;
  end
  assign pg_in = pg_raw & ~drop_mask;

  typedef struct {
    int         t;
    logic [3:0] rail;
    logic       pgd;
    logic       flt;
    logic [1:0] frail;
    logic [2:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  compared = 0;
  int  failed   = 0;
  bit  mon_en   = 1'b0;

  function automatic void push(int t, logic [3:0] rail, logic pgd, logic flt,
                               logic [1:0] frail, logic [2:0] st);
    ev_t e;
    e.t = t; e.rail = rail; e.pgd = pgd; e.flt = flt; e.frail = frail; e.st = st;
    exp_q.push_back(e);
  endfunction

  function automatic logic [3:0] low_mask(int n);
    return 4'((1 << n) - 1);
  endfunction

  logic [7:0] prev_out = '0;
  logic [2:0] prev_st  = S_IDLE;
  always @(negedge sysclk) begin
    logic [7:0] cur_out;
    ev_t        e;
    cur_out = {rail_en, power_good, fault, fault_rail};
    if (mon_en && ((cur_out != prev_out) || (state == S_IDLE && prev_st != S_IDLE))) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_event: cycle %0d rail_en=%b pg=%b fault=%b fault_rail=%0d state=%0d, required no change",
                 cyc, rail_en, power_good, fault, fault_rail, state);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || e.rail !== rail_en || e.pgd !== power_good || e.flt !== fault ||
            e.frail !== fault_rail || e.st !== state) begin
          failed++;
          $display("FAIL event: got cycle=%0d rail_en=%b pg=%b fault=%b fault_rail=%0d state=%0d, required cycle=%0d rail_en=%b pg=%b fault=%b fault_rail=%0d state=%0d",
                   cyc, rail_en, power_good, fault, fault_rail, state,
                   e.t, e.rail, e.pgd, e.flt, e.frail, e.st);
        end else begin
          $display("event cycle=%0d rail_en=%b pg=%b fault=%b fault_rail=%0d state=%0d ok",
                   cyc, rail_en, power_good, fault, fault_rail, state);
        end
      end
    end
    prev_out = cur_out;
    prev_st  = state;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_edge(int e);
    while (cyc < e) @(negedge sysclk);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    if (exp_q.size() > 0) begin
      compared++;
      failed++;
      $display("FAIL drain_timeout: got %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_ramp(int t0, int last, bit full);
    for (int i = 0; i <= last; i++) push(t0 + STEP * i, low_mask(i + 1), 1'b0, 1'b0, 2'd0, S_RAMP);
    if (full) push(t0 + STEP * N, 4'hF, 1'b1, 1'b0, 2'd0, S_ON);
  endtask

  task automatic push_down(int a, int idx);
    for (int m = 0; m <= idx; m++) push(a + OFFD * m, low_mask(idx - m), 1'b0, 1'b0, 2'd0, S_DOWN);
    push(a + OFFD * (idx + 1), 4'h0, 1'b0, 1'b0, 2'd0, S_IDLE);
  endtask

  task automatic start_up(output int t0);
    t0     = cyc + 1;
    enable = 1'b1;
  endtask

  task automatic quiet_gap();
    repeat (6) @(negedge sysclk);
  endtask

  task automatic run_full_up_down();
    int t0, a;
    quiet_gap();
    start_up(t0);
    push_ramp(t0, N - 1, 1'b1);
    a = t0 + STEP * N + $urandom_range(1, 20);
    wait_edge(a - 1);
    push_down(a, N - 1);
    enable = 1'b0;
    drain(400);
  endtask

  task automatic run_stuck(int k);
    int t0, f, e;
    quiet_gap();
    drop_mask = 4'(1 << k);
    start_up(t0);
    push_ramp(t0, k, 1'b0);
    f = t0 + STEP * k + TIMEOUT;
    push(f, 4'h0, 1'b0, 1'b1, 2'(k), S_FAULT);
    e = f + $urandom_range(1, 15);
    wait_edge(e - 1);
    push(e, 4'h0, 1'b0, 1'b0, 2'd0, S_IDLE);
    enable = 1'b0;
    drain(400);
    drop_mask = '0;
  endtask

  task automatic run_pg_loss(logic [3:0] mask, bit same_cycle);
    int t0, k, j, e;
    quiet_gap();
    start_up(t0);
    push_ramp(t0, N - 1, 1'b1);
    wait_edge(t0 + STEP * N + $urandom_range(1, 10));
    k = cyc;
    j = 0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) j = i;
    drop_mask = mask;
    push(k + 3, 4'h0, 1'b0, 1'b1, 2'(j), S_FAULT);
    e = same_cycle ? k + 4 : k + 3 + $urandom_range(1, 10);
    push(e, 4'h0, 1'b0, 1'b0, 2'd0, S_IDLE);
    wait_edge(e - 2);
    if (same_cycle) enable = 1'b0;
    wait_edge(e - 1);
    enable = 1'b0;
    drain(400);
    drop_mask = '0;
  endtask

  task automatic run_abort(int offset);
    int t0, a, idx, idle_t;
    quiet_gap();
    start_up(t0);
    a   = t0 + offset;
    idx = (a - 1 - t0) / STEP;
    push_ramp(t0, idx, 1'b0);
    push_down(a, idx);
    idle_t = a + OFFD * (idx + 1);
    wait_edge(a - 1);
    enable    = 1'b0;
    drop_mask = 4'($urandom_range(0, 15));
    wait_edge(a + 1);
    enable = 1'b1;
    wait_edge(idle_t - 2);
    enable = 1'b0;
    drain(400);
    drop_mask = '0;
  endtask

  task automatic run_reset_mid_settle();
    int t0;
    quiet_gap();
    start_up(t0);
    push(t0, 4'h1, 1'b0, 1'b0, 2'd0, S_RAMP);
    wait_edge(t0 + PG_DELAY + SYNC_LAT + 1);
    drain(10);
    mon_en = 1'b0;
    #1 reset_INV = 1'b0;
    #1;
    chk("async_reset_rail_en", 32'(rail_en), 32'h0);
    chk("async_reset_power_good", 32'(power_good), 32'h0);
    chk("async_reset_fault", 32'(fault), 32'h0);
    chk("async_reset_fault_rail", 32'(fault_rail), 32'h0);
    chk("async_reset_state", 32'(state), 32'(S_IDLE));
    enable = 1'b0;
    #1 reset_INV = 1'b1;
    @(negedge sysclk);
    #1 mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    enable    = 1'b0;
    reset_INV = 1'b1;
    #2 reset_INV = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("reset_rail_en", 32'(rail_en), 32'h0);
    chk("reset_power_good", 32'(power_good), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_fault_rail", 32'(fault_rail), 32'h0);
    chk("reset_state", 32'(state), 32'(S_IDLE));
    reset_INV = 1'b1;
    @(negedge sysclk);
    #1 mon_en = 1'b1;

    run_full_up_down();
    run_stuck(2);
    run_pg_loss(4'b1010, 1'b0);
    run_abort(2 * STEP + 2);
    run_pg_loss(4'b0100, 1'b1);
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: run_full_up_down();
        1: run_stuck($urandom_range(0, N - 1));
        2: run_pg_loss(4'($urandom_range(1, 15)), 1'b0);
        3: run_abort($urandom_range(1, STEP * N));
        default: run_pg_loss(4'($urandom_range(1, 15)), 1'b1);
      endcase
    end
    run_reset_mid_settle();
    run_full_up_down();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
